// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the CPU run/step sequencer: FSM states, display
// source indices and the display-rotation helper.
package cpu_ctrl_pkg;

  localparam int DATA_W   = 32;
  localparam int DISP_NUM = 5;

  localparam logic [1:0] S_RST  = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  localparam logic [2:0] DISP_TOTAL  = 3'd0;
  localparam logic [2:0] DISP_UNCOND = 3'd1;
  localparam logic [2:0] DISP_COND   = 3'd2;
  localparam logic [2:0] DISP_BUBBLE = 3'd3;
  localparam logic [2:0] DISP_LED    = 3'd4;

  typedef logic [2:0] disp_idx_t;

  function automatic disp_idx_t disp_next(input disp_idx_t idx);
    return (idx == DISP_LED) ? DISP_TOTAL : idx + 3'd1;
  endfunction

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// Board-side bundle of the run controller: buttons, display controls, CPU
// statistics in, CPU reset/go and display bus out.
interface cpu_run_ctrl_if;
  import cpu_ctrl_pkg::*;

  logic              btn_go;
  logic              btn_reset;
  logic              auto_rot;
  logic [2:0]        disp_sel_in;
  logic [DATA_W-1:0] total_cycles;
  logic [DATA_W-1:0] uncondi_branch_num;
  logic [DATA_W-1:0] condi_branch_num;
  logic [DATA_W-1:0] bubble_num;
  logic [DATA_W-1:0] led_data_in;
  logic              cpu_rst;
  logic              cpu_go;
  logic [DATA_W-1:0] disp_value;
  logic [2:0]        disp_idx;

  modport master (
    input  btn_go, btn_reset, auto_rot, disp_sel_in,
    input  total_cycles, uncondi_branch_num, condi_branch_num, bubble_num, led_data_in,
    output cpu_rst, cpu_go, disp_value, disp_idx
  );

  modport slave (
    output btn_go, btn_reset, auto_rot, disp_sel_in,
    output total_cycles, uncondi_branch_num, condi_branch_num, bubble_num, led_data_in,
    input  cpu_rst, cpu_go, disp_value, disp_idx
  );

endinterface

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus level debouncer for one raw board button;
// emits a one-cycle press pulse on each accepted 0->1 transition.
module btn_debounce #(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press
);

  logic        sync_p0;
  logic        sync_p1;
  logic [19:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      level   <= 1'b0;
      press   <= 1'b0;
      cnt     <= '0;
    end else begin
      sync_p0 <= raw;
      // sync_p1 is the first flop safe to use in logic
      sync_p1 <= sync_p0;
      press   <= 1'b0;
      if (sync_p1 == level) begin
        cnt <= '0;
      end else if (cnt == DEBOUNCE_CYCLES - 20'd1) begin
        level <= sync_p1;
        press <= sync_p1;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 20'd1;
      end
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/step sequencer for the pipeline CPU: stretched CPU reset, go pulse for
// stepping past syscall halts, and a time-multiplexed statistics display.
module cpu_run_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000,
  parameter logic [7:0]  RST_STRETCH     = 8'd16,
  parameter logic [23:0] DISP_PERIOD     = 24'd5000000
) (
  input logic            clk,
  input logic            rst,
  cpu_run_ctrl_if.master bus
);

  logic go_press;
  logic rst_press;
  logic go_level;
  logic rst_level;
  logic unused_levels;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_go_btn (
    .clk   (clk),
    .rst   (rst),
    .raw   (bus.btn_go),
    .level (go_level),
    .press (go_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_rst_btn (
    .clk   (clk),
    .rst   (rst),
    .raw   (bus.btn_reset),
    .level (rst_level),
    .press (rst_press)
  );

  assign unused_levels = go_level ^ rst_level;

  logic [1:0] state;
  logic [7:0] stretch_cnt;
  logic       go_q;

  // A simultaneous go+reset detours through S_HOLD so reset always wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_RST;
      stretch_cnt <= '0;
      go_q        <= 1'b0;
    end else begin
      go_q <= 1'b0;
      case (state)
        S_RST: begin
          if (rst_press) begin
            stretch_cnt <= '0;
          end else if (stretch_cnt == RST_STRETCH - 8'd1) begin
            state       <= S_RUN;
            stretch_cnt <= '0;
          end else begin
            stretch_cnt <= stretch_cnt + 8'd1;
          end
        end
        S_RUN: begin
          if (rst_press && go_press) begin
            state <= S_HOLD;
          end else if (rst_press) begin
            state       <= S_RST;
            stretch_cnt <= '0;
          end else begin
            go_q <= go_press;
          end
        end
        default: begin
          state       <= S_RST;
          stretch_cnt <= '0;
        end
      endcase
    end
  end

  assign bus.cpu_rst = (state != S_RUN);
  assign bus.cpu_go  = go_q;

  logic [23:0]       rot_cnt;
  disp_idx_t         disp_idx_p0;
  logic [DATA_W-1:0] disp_value_p1;
  logic [DATA_W-1:0] sel_value;

  always_comb begin
    sel_value = bus.total_cycles;
    case (disp_idx_p0)
      DISP_UNCOND: sel_value = bus.uncondi_branch_num;
      DISP_COND:   sel_value = bus.condi_branch_num;
      DISP_BUBBLE: sel_value = bus.bubble_num;
      DISP_LED:    sel_value = bus.led_data_in;
      default:     sel_value = bus.total_cycles;
    endcase
  end

  // Stage p0: source index; stage p1: selected value, one cycle behind.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rot_cnt       <= '0;
      disp_idx_p0   <= DISP_TOTAL;
      disp_value_p1 <= '0;
    end else begin
      disp_value_p1 <= sel_value;
      if (bus.auto_rot) begin
        if (rot_cnt == DISP_PERIOD - 24'd1) begin
          rot_cnt     <= '0;
          disp_idx_p0 <= disp_next(disp_idx_p0);
        end else begin
          rot_cnt <= rot_cnt + 24'd1;
        end
      end else begin
        rot_cnt <= '0;
        if (bus.disp_sel_in <= DISP_LED) begin
          disp_idx_p0 <= bus.disp_sel_in;
        end
      end
    end
  end

  assign bus.disp_idx   = disp_idx_p0;
  assign bus.disp_value = disp_value_p1;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: timed expectations go into a scoreboard queue and
// are compared on the falling edge of the cycle they are due.
module tb_cpu_run_ctrl;
  import cpu_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;

  cpu_run_ctrl_if ifc ();
  cpu_run_ctrl_if ifl ();

  cpu_run_ctrl #(
    .DEBOUNCE_CYCLES (20'd4),
    .RST_STRETCH     (8'd3),
    .DISP_PERIOD     (24'd5)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  // Long stretch so a second reset press can land inside S_RST.
  cpu_run_ctrl #(
    .DEBOUNCE_CYCLES (20'd4),
    .RST_STRETCH     (8'd16),
    .DISP_PERIOD     (24'd5)
  ) u_dut_long (
    .clk (clk),
    .rst (rst),
    .bus (ifl)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int go_cnt   = 0;
  int viol     = 0;
  logic go_prev = 1'b0;

  typedef struct {
    int          cyc;
    int          sig;
    logic [31:0] exp;
    string       name;
  } sb_t;

  sb_t sbq[$];

  typedef struct packed {
    logic [2:0]  sel;
    logic [2:0]  idx;
    logic [31:0] val;
  } vec_t;

  vec_t        vecs[8];
  logic [31:0] vals[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_at(input int c, input int sig, input logic [31:0] e, input string n);
    sb_t s;
    s.cyc  = c;
    s.sig  = sig;
    s.exp  = e;
    s.name = n;
    sbq.push_back(s);
  endtask

  function automatic logic [31:0] sample(input int sig);
    case (sig)
      0:       return {31'd0, ifc.cpu_rst};
      1:       return {31'd0, ifc.cpu_go};
      2:       return ifc.disp_value;
      3:       return {29'd0, ifc.disp_idx};
      default: return {31'd0, ifl.cpu_rst};
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int i = sbq.size() - 1; i >= 0; i--) begin
      if (sbq[i].cyc < cyc) begin
        chk({sbq[i].name, "_missed"}, cyc, sbq[i].cyc);
        sbq.delete(i);
      end else if (sbq[i].cyc == cyc) begin
        chk(sbq[i].name, sample(sbq[i].sig), sbq[i].exp);
        sbq.delete(i);
      end
    end
    if (rst) begin
      if (ifc.cpu_go) go_cnt++;
      if (ifc.cpu_go && (ifc.cpu_rst || go_prev)) viol++;
    end
    go_prev = ifc.cpu_go;
  end

  initial begin
    int c;
    int r;
    int g0;
    logic [31:0] prev;

    vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33; vals[3] = 32'h44; vals[4] = 32'h55;
    vecs[0] = '{3'd3, 3'd3, 32'h44};
    vecs[1] = '{3'd6, 3'd3, 32'h44};
    vecs[2] = '{3'd0, 3'd0, 32'h11};
    vecs[3] = '{3'd4, 3'd4, 32'h55};
    vecs[4] = '{3'd7, 3'd4, 32'h55};
    vecs[5] = '{3'd1, 3'd1, 32'h22};
    vecs[6] = '{3'd5, 3'd1, 32'h22};
    vecs[7] = '{3'd2, 3'd2, 32'h33};

    ifc.btn_go = 1'b0; ifc.btn_reset = 1'b0; ifc.auto_rot = 1'b0; ifc.disp_sel_in = 3'd0;
    ifc.total_cycles = vals[0]; ifc.uncondi_branch_num = vals[1]; ifc.condi_branch_num = vals[2];
    ifc.bubble_num = vals[3]; ifc.led_data_in = vals[4];
    ifl.btn_go = 1'b0; ifl.btn_reset = 1'b0; ifl.auto_rot = 1'b0; ifl.disp_sel_in = 3'd0;
    ifl.total_cycles = '0; ifl.uncondi_branch_num = '0; ifl.condi_branch_num = '0;
    ifl.bubble_num = '0; ifl.led_data_in = '0;

    tick(2);
    chk("reset_cpu_rst", {31'd0, ifc.cpu_rst}, 32'd1);
    chk("reset_cpu_go", {31'd0, ifc.cpu_go}, 32'd0);
    chk("reset_disp_value", ifc.disp_value, 32'd0);
    chk("reset_disp_idx", {29'd0, ifc.disp_idx}, 32'd0);

    // Power-up stretch; long instance gets a reset press mid-stretch.
    c = cyc;
    rst = 1'b1;
    ifl.btn_reset = 1'b1;
    expect_at(c + 1, 0, 1, "pu_rst_c1");
    expect_at(c + 2, 0, 1, "pu_rst_c2");
    expect_at(c + 3, 0, 0, "pu_rst_release");
    expect_at(c + 3, 3, 0, "pu_idx");
    expect_at(c + 16, 4, 1, "long_restart_held");
    expect_at(c + 22, 4, 1, "long_restart_last");
    expect_at(c + 23, 4, 0, "long_restart_release");
    g0 = go_cnt;
    tick(26);
    chk("pu_no_go", go_cnt - g0, 0);

    // Two-cycle glitch is rejected.
    ifc.btn_go = 1'b1;
    tick(2);
    ifc.btn_go = 1'b0;
    g0 = go_cnt;
    tick(12);
    chk("glitch_no_go", go_cnt - g0, 0);

    // Held go button: single pulse 7 cycles after the raw edge.
    c = cyc;
    ifc.btn_go = 1'b1;
    expect_at(c + 6, 1, 0, "go_early");
    expect_at(c + 7, 1, 1, "go_pulse");
    expect_at(c + 7, 0, 0, "go_rst_low");
    expect_at(c + 8, 1, 0, "go_width");
    g0 = go_cnt;
    tick(10);
    ifc.btn_go = 1'b0;
    tick(10);
    chk("go_one_pulse", go_cnt - g0, 1);

    // Plain reset press in S_RUN.
    c = cyc;
    ifc.btn_reset = 1'b1;
    expect_at(c + 6, 0, 0, "rstp_before");
    expect_at(c + 7, 0, 1, "rstp_first");
    expect_at(c + 9, 0, 1, "rstp_last");
    expect_at(c + 10, 0, 0, "rstp_release");
    tick(12);
    ifc.btn_reset = 1'b0;
    tick(10);

    // Aligned go + reset: S_HOLD then stretch, no go pulse.
    c = cyc;
    ifc.btn_go = 1'b1;
    ifc.btn_reset = 1'b1;
    expect_at(c + 6, 0, 0, "hold_before");
    expect_at(c + 7, 0, 1, "hold_rst");
    expect_at(c + 7, 1, 0, "hold_no_go_c7");
    expect_at(c + 8, 0, 1, "hold_stretch1");
    expect_at(c + 8, 1, 0, "hold_no_go_c8");
    expect_at(c + 9, 0, 1, "hold_stretch2");
    expect_at(c + 10, 0, 1, "hold_stretch3");
    expect_at(c + 11, 0, 0, "hold_release");
    g0 = go_cnt;
    tick(12);
    ifc.btn_go = 1'b0;
    ifc.btn_reset = 1'b0;
    tick(10);
    chk("hold_no_go", go_cnt - g0, 0);

    // Manual select table.
    prev = 32'h11;
    for (int i = 0; i < 8; i++) begin
      c = cyc;
      ifc.disp_sel_in = vecs[i].sel;
      expect_at(c + 1, 3, {29'd0, vecs[i].idx}, $sformatf("man_idx_%0d", i));
      expect_at(c + 1, 2, prev, $sformatf("man_lag_%0d", i));
      expect_at(c + 2, 2, vecs[i].val, $sformatf("man_val_%0d", i));
      prev = vecs[i].val;
      tick(2);
    end

    // Auto rotation from idx 0.
    ifc.disp_sel_in = 3'd0;
    tick(2);
    c = cyc;
    ifc.auto_rot = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      expect_at(c + 5 * k - 1, 3, (k - 1) % 5, $sformatf("rot_hold_%0d", k));
      expect_at(c + 5 * k, 3, k % 5, $sformatf("rot_step_%0d", k));
      expect_at(c + 5 * k + 1, 2, vals[k % 5], $sformatf("rot_val_%0d", k));
    end
    tick(27);
    ifc.auto_rot = 1'b0;
    tick(2);

    // Async reset mid-debounce; the half-counted press is discarded.
    ifc.disp_sel_in = 3'd2;
    tick(3);
    ifc.btn_go = 1'b1;
    tick(3);
    #2;
    rst = 1'b0;
    #1;
    chk("async_cpu_rst", {31'd0, ifc.cpu_rst}, 32'd1);
    chk("async_cpu_go", {31'd0, ifc.cpu_go}, 32'd0);
    chk("async_disp_value", ifc.disp_value, 32'd0);
    chk("async_disp_idx", {29'd0, ifc.disp_idx}, 32'd0);
    @(negedge clk);
    r = cyc;
    rst = 1'b1;
    expect_at(r + 1, 0, 1, "ar_rst_c1");
    expect_at(r + 1, 3, 2, "ar_idx");
    expect_at(r + 1, 2, 32'h11, "ar_val_lag");
    expect_at(r + 2, 2, 32'h33, "ar_val");
    expect_at(r + 3, 0, 0, "ar_rst_release");
    expect_at(r + 6, 1, 0, "ar_go_early");
    expect_at(r + 7, 1, 1, "ar_go_redebounced");
    expect_at(r + 8, 1, 0, "ar_go_width");
    g0 = go_cnt;
    tick(12);
    ifc.btn_go = 1'b0;
    tick(10);
    chk("ar_one_pulse", go_cnt - g0, 1);

    for (int i = 0; i < 50 && sbq.size() > 0; i++) tick(1);
    chk("sb_drain", sbq.size(), 0);
    chk("go_invariant", viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
